// File: rtl/gbox_pkg.sv
// Shared constants, lock-state type and header helper for the 66b block path.
// Used by the header seeker, the block aligner and the descrambler front end.
package gbox_pkg;

  localparam logic [1:0] c_DATA_HEADER = 2'b01;
  localparam logic [1:0] c_CMD_HEADER  = 2'b10;

  localparam int c_BLK_W      = 66;
  localparam int c_WIN_W      = 67;
  localparam int c_MAX_OFFSET = 65;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Only the two sync headers with a transition are legal.
  function automatic logic header_valid(input logic [1:0] hdr);
    return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
  endfunction

endpackage

// File: rtl/blk_lock_fsm.sv
// Block-lock state machine: hunts for LOCK_CNT consecutive good headers, then
// monitors bad headers per MON_WIN-block window and drops lock at BAD_MAX.
module blk_lock_fsm
  import gbox_pkg::*;
#(
  parameter int LOCK_CNT = 32,
  parameter int BAD_MAX  = 16,
  parameter int MON_WIN  = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic blk_valid,
  input  logic header_ok,
  input  logic offset_changed,
  output logic lock
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(BAD_MAX + 1);
  localparam int WCNT_W = $clog2(MON_WIN);

  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_LAST = BAD_W'(BAD_MAX - 1);
  localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(MON_WIN - 1);

  lock_state_e       state;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_inc;
  logic [BAD_W-1:0]  bad_cnt;
  logic [WCNT_W-1:0] win_cnt;
  logic              lock_lost;
  logic              win_wrap;

  // NOTE: every signal below is assigned on every path through the block, so
  // no storage is inferred; a missing assignment here would create a latch.
  always_comb begin
    good_inc  = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
    lock_lost = blk_valid && !header_ok && (bad_cnt == BAD_LAST);
    win_wrap  = (win_cnt == WIN_LAST);
  end

  assign lock = (state == LOCKED);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would make update order matter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
      bad_cnt  <= '0;
      win_cnt  <= '0;
    end else if (state == UNLOCKED) begin
      if (offset_changed) begin
        good_cnt <= '0;
      end else if (blk_valid) begin
        if (!header_ok) begin
          good_cnt <= '0;
        end else begin
          good_cnt <= good_inc;
          if (good_inc == GOOD_MAX) begin
            state   <= LOCKED;
            bad_cnt <= '0;
            win_cnt <= '0;
          end
        end
      end
    end else if (lock_lost) begin
      // Losing lock wins over a coincident window wrap.
      state    <= UNLOCKED;
      good_cnt <= '0;
      bad_cnt  <= '0;
      win_cnt  <= '0;
    end else if (blk_valid) begin
      win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
      if (win_wrap) begin
        bad_cnt <= '0;
      end else if (!header_ok) begin
        bad_cnt <= bad_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_aligner66.sv
// 66b block aligner: captures gearbox windows, extracts blocks at the seeker's
// offset, and emits them with header-error flags once block lock is held.
module block_aligner66
  import gbox_pkg::*;
#(
  parameter int LOCK_CNT = 32,
  parameter int BAD_MAX  = 16,
  parameter int MON_WIN  = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [193:0] gbox_buffer,
  input  logic [5:0]   gbox_cnt,
  input  logic         buffer_dv,
  input  logic [6:0]   block_offset,
  output logic [1:0]   blk_hdr_o,
  output logic [63:0]  blk_data_o,
  output logic         blk_dv_o,
  output logic         hdr_err_o,
  output logic         blk_lock_o,
  output logic [6:0]   offset_used_o
);

  localparam logic [6:0] MAX_OFFSET = 7'(c_MAX_OFFSET);

  logic [c_WIN_W-1:0]   win;
  logic [c_WIN_W-1:0]   prev_win;
  logic                 prev_valid;
  logic [2*c_WIN_W-1:0] cat;
  logic [7:0]           win_top;
  logic [6:0]           hdr_top;
  logic [7:0]           pay_top;
  logic [6:0]           offset_used;
  logic [1:0]           hdr;
  logic [c_BLK_W-3:0]   payload;
  logic                 header_ok;
  logic                 blk_valid;
  logic                 offset_load;
  logic                 offset_changed;
  logic                 lock;

  always_comb begin
    win_top        = 8'd193 - {2'b00, gbox_cnt};
    win            = gbox_buffer[win_top -: c_WIN_W];
    cat            = {win, prev_win};
    hdr_top        = offset_used + 7'd1;
    pay_top        = {1'b0, offset_used} + 8'd65;
    hdr            = prev_win[hdr_top -: 2];
    payload        = cat[pay_top -: (c_BLK_W - 2)];
    header_ok      = header_valid(hdr);
    blk_valid      = buffer_dv && prev_valid;
    // The offset only tracks the seeker while hunting; lock freezes it.
    offset_load    = buffer_dv && !lock && (block_offset <= MAX_OFFSET);
    offset_changed = offset_load && (block_offset != offset_used);
  end

  blk_lock_fsm #(
    .LOCK_CNT(LOCK_CNT),
    .BAD_MAX (BAD_MAX),
    .MON_WIN (MON_WIN)
  ) u_lock_fsm (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .blk_valid     (blk_valid),
    .header_ok     (header_ok),
    .offset_changed(offset_changed),
    .lock          (lock)
  );

  // NOTE: the window registers are reset along with prev_valid so that a reset
  // mid-block leaves no stale bits that could surface in a later block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_win    <= '0;
      prev_valid  <= 1'b0;
      offset_used <= '0;
      blk_hdr_o   <= '0;
      blk_data_o  <= '0;
      blk_dv_o    <= 1'b0;
      hdr_err_o   <= 1'b0;
      blk_lock_o  <= 1'b0;
    end else begin
      blk_dv_o   <= 1'b0;
      hdr_err_o  <= 1'b0;
      blk_lock_o <= lock;
      if (buffer_dv) begin
        prev_win   <= win;
        prev_valid <= 1'b1;
      end
      if (offset_load) begin
        offset_used <= block_offset;
      end
      // The block that triggers loss of lock is still emitted.
      if (blk_valid && lock) begin
        blk_dv_o   <= 1'b1;
        hdr_err_o  <= !header_ok;
        blk_hdr_o  <= hdr;
        blk_data_o <= payload;
      end
    end
  end

  assign offset_used_o = offset_used;

endmodule

// File: tb/tb_block_aligner66.sv
// Directed bench for block_aligner66: builds a 66b block stream at a chosen
// offset, feeds it through random gearbox positions and checks the outputs.
module tb_block_aligner66;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [193:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic         buffer_dv;
  logic [6:0]   block_offset;
  logic [1:0]   blk_hdr_o;
  logic [63:0]  blk_data_o;
  logic         blk_dv_o;
  logic         hdr_err_o;
  logic         blk_lock_o;
  logic [6:0]   offset_used_o;

  int checks = 0;
  int errors = 0;

  logic [65:0] prev_blk = '0;
  logic [65:0] last_exp = '0;

  block_aligner66 #(
    .LOCK_CNT(32),
    .BAD_MAX (16),
    .MON_WIN (64)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .gbox_buffer  (gbox_buffer),
    .gbox_cnt     (gbox_cnt),
    .buffer_dv    (buffer_dv),
    .block_offset (block_offset),
    .blk_hdr_o    (blk_hdr_o),
    .blk_data_o   (blk_data_o),
    .blk_dv_o     (blk_dv_o),
    .hdr_err_o    (hdr_err_o),
    .blk_lock_o   (blk_lock_o),
    .offset_used_o(offset_used_o)
  );

  always #5 clk_i = ~clk_i;

  // Window that carries the head of cur at bit o and the tail of prv below it.
  function automatic logic [66:0] mk_win(input logic [65:0] cur, input logic [65:0] prv,
                                         input int o);
    logic [66:0] c;
    logic [66:0] p;
    c = {1'b0, cur};
    p = {1'b0, prv};
    return (c << o) | (p >> (67 - o));
  endfunction

  function automatic logic [65:0] new_blk(input logic [1:0] h);
    return {$urandom(), $urandom(), h};
  endfunction

  function automatic logic [1:0] good_hdr(input int i);
    return (i % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic beat(input logic [65:0] blk, input int o, input logic [6:0] boff);
    logic [193:0] bufv;
    int c;
    c = $urandom_range(0, 63);
    for (int i = 0; i < 194; i++) bufv[i] = 1'($urandom_range(0, 1));
    bufv[193-c -: 67] = mk_win(blk, prev_blk, o);
    gbox_buffer  = bufv;
    gbox_cnt     = 6'(c);
    block_offset = boff;
    buffer_dv    = 1'b1;
    @(posedge clk_i);
    #1;
    buffer_dv = 1'b0;
    last_exp  = prev_blk;
    prev_blk  = blk;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    buffer_dv = 1'b0;
    idle(2);
    rst_i = 1'b0;
  endtask

  // 33 good beats: the first only fills the window, the next 32 reach lock.
  task automatic acquire(input int o, output int dv_seen);
    dv_seen = 0;
    for (int i = 0; i < 33; i++) begin
      beat(new_blk(good_hdr(i)), o, 7'(o));
      if (blk_dv_o) dv_seen++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    beat(new_blk(2'b01), 10, 7'd10);
    beat(new_blk(2'b10), 10, 7'd10);
    checks++;
    if ({blk_dv_o, hdr_err_o, blk_lock_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: dv/err/lock=%b expected 000", {blk_dv_o, hdr_err_o, blk_lock_o});
    end
    checks++;
    if (offset_used_o !== 7'd0) begin
      errors++;
      $display("FAIL reset_offset: got %0d expected 0", offset_used_o);
    end
    checks++;
    if ({blk_hdr_o, blk_data_o} !== 66'd0) begin
      errors++;
      $display("FAIL reset_block: got %h expected 0", {blk_data_o, blk_hdr_o});
    end
    rst_i = 1'b0;
  endtask

  task automatic test_lock_offset(input int o);
    int dv_seen;
    do_reset();
    acquire(o, dv_seen);
    checks++;
    if (dv_seen != 0) begin
      errors++;
      $display("FAIL unlocked_dv o=%0d: got %0d pulses expected 0", o, dv_seen);
    end
    checks++;
    if (blk_lock_o !== 1'b0) begin
      errors++;
      $display("FAIL early_lock o=%0d: got %b expected 0", o, blk_lock_o);
    end
    beat(new_blk(2'b01), o, 7'(o));
    checks++;
    if ({blk_dv_o, hdr_err_o, blk_lock_o} !== 3'b101) begin
      errors++;
      $display("FAIL first_block_flags o=%0d: dv/err/lock=%b expected 101", o,
               {blk_dv_o, hdr_err_o, blk_lock_o});
    end
    checks++;
    if ({blk_data_o, blk_hdr_o} !== last_exp) begin
      errors++;
      $display("FAIL first_block o=%0d: got %h expected %h", o, {blk_data_o, blk_hdr_o}, last_exp);
    end
    checks++;
    if (offset_used_o !== 7'(o)) begin
      errors++;
      $display("FAIL offset_used o=%0d: got %0d", o, offset_used_o);
    end
    for (int k = 0; k < 6; k++) begin
      beat(new_blk(good_hdr(k)), o, 7'(o));
      checks++;
      if ({blk_dv_o, blk_data_o, blk_hdr_o} !== {1'b1, last_exp}) begin
        errors++;
        $display("FAIL stream o=%0d k=%0d: dv=%b got %h expected %h", o, k, blk_dv_o,
                 {blk_data_o, blk_hdr_o}, last_exp);
      end
    end
  endtask

  task automatic test_bad_headers();
    int dv_seen;
    int dv_cnt;
    int err_cnt;
    int flag_bad;
    logic [1:0] h;
    do_reset();
    acquire(10, dv_seen);
    dv_cnt   = 0;
    err_cnt  = 0;
    flag_bad = 0;
    for (int i = 0; i < 64; i++) begin
      h = (i % 4 == 1 && i < 60) ? ((i % 8 == 5) ? 2'b11 : 2'b00) : good_hdr(i);
      beat(new_blk(h), 10, 7'd10);
      if (blk_dv_o) begin
        dv_cnt++;
        if (hdr_err_o) err_cnt++;
        if (hdr_err_o !== !(last_exp[1:0] == 2'b01 || last_exp[1:0] == 2'b10)) flag_bad++;
      end
    end
    checks++;
    if (dv_cnt != 64 || err_cnt != 15) begin
      errors++;
      $display("FAIL window15_counts: dv=%0d err=%0d expected 64 and 15", dv_cnt, err_cnt);
    end
    checks++;
    if (flag_bad != 0) begin
      errors++;
      $display("FAIL window15_flags: %0d blocks with wrong hdr_err_o expected 0", flag_bad);
    end
    checks++;
    if (blk_lock_o !== 1'b1) begin
      errors++;
      $display("FAIL window15_lock: got %b expected 1", blk_lock_o);
    end
    err_cnt = 0;
    for (int j = 0; j < 31; j++) begin
      beat(new_blk((j % 2 == 0) ? 2'b00 : good_hdr(j)), 10, 7'd10);
      if (blk_dv_o && hdr_err_o) err_cnt++;
    end
    checks++;
    if (blk_lock_o !== 1'b1 || err_cnt != 15) begin
      errors++;
      $display("FAIL window16_before: lock=%b err=%0d expected 1 and 15", blk_lock_o, err_cnt);
    end
    beat(new_blk(2'b01), 10, 7'd10);
    checks++;
    if ({blk_dv_o, hdr_err_o, blk_lock_o} !== 3'b111) begin
      errors++;
      $display("FAIL window16_trigger: dv/err/lock=%b expected 111", {blk_dv_o, hdr_err_o, blk_lock_o});
    end
    beat(new_blk(2'b10), 10, 7'd10);
    checks++;
    if ({blk_dv_o, blk_lock_o} !== 2'b00) begin
      errors++;
      $display("FAIL window16_drop: dv/lock=%b expected 00", {blk_dv_o, blk_lock_o});
    end
  endtask

  task automatic test_offset_change();
    int dv_seen;
    do_reset();
    for (int i = 0; i < 21; i++) beat(new_blk(good_hdr(i)), 10, 7'd10);
    dv_seen = 0;
    for (int i = 0; i < 33; i++) begin
      beat(new_blk(good_hdr(i)), 30, 7'd30);
      if (blk_dv_o) dv_seen++;
      if (i == 0) begin
        checks++;
        if (offset_used_o !== 7'd30) begin
          errors++;
          $display("FAIL change_offset: got %0d expected 30", offset_used_o);
        end
      end
    end
    checks++;
    if (dv_seen != 0 || blk_lock_o !== 1'b0) begin
      errors++;
      $display("FAIL change_restart: dv=%0d lock=%b expected 0 and 0", dv_seen, blk_lock_o);
    end
    beat(new_blk(2'b01), 30, 7'd30);
    checks++;
    if ({blk_dv_o, blk_lock_o, blk_data_o, blk_hdr_o} !== {2'b11, last_exp}) begin
      errors++;
      $display("FAIL change_lock: dv=%b lock=%b got %h expected %h", blk_dv_o, blk_lock_o,
               {blk_data_o, blk_hdr_o}, last_exp);
    end
  endtask

  task automatic test_offset_hold();
    int dv_seen;
    do_reset();
    for (int i = 0; i < 3; i++) beat(new_blk(good_hdr(i)), 10, 7'd10);
    beat(new_blk(2'b01), 10, 7'd100);
    checks++;
    if (offset_used_o !== 7'd10) begin
      errors++;
      $display("FAIL hold_100: got %0d expected 10", offset_used_o);
    end
    beat(new_blk(2'b10), 10, 7'd66);
    checks++;
    if (offset_used_o !== 7'd10) begin
      errors++;
      $display("FAIL hold_66: got %0d expected 10", offset_used_o);
    end
    do_reset();
    acquire(10, dv_seen);
    beat(new_blk(2'b01), 10, 7'd10);
    beat(new_blk(2'b10), 10, 7'd20);
    checks++;
    if ({blk_dv_o, offset_used_o, blk_data_o, blk_hdr_o} !== {1'b1, 7'd10, last_exp}) begin
      errors++;
      $display("FAIL frozen_20: dv=%b off=%0d got %h expected %h", blk_dv_o, offset_used_o,
               {blk_data_o, blk_hdr_o}, last_exp);
    end
    beat(new_blk(2'b01), 10, 7'd0);
    checks++;
    if ({blk_dv_o, offset_used_o, blk_data_o, blk_hdr_o} !== {1'b1, 7'd10, last_exp}) begin
      errors++;
      $display("FAIL frozen_0: dv=%b off=%0d got %h expected %h", blk_dv_o, offset_used_o,
               {blk_data_o, blk_hdr_o}, last_exp);
    end
  endtask

  task automatic test_gaps();
    int dv_seen;
    dv_seen = 0;
    for (int i = 0; i < 7; i++) begin
      idle(1);
      if (blk_dv_o) dv_seen++;
    end
    checks++;
    if (dv_seen != 0 || blk_lock_o !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold: dv=%0d lock=%b expected 0 and 1", dv_seen, blk_lock_o);
    end
    beat(new_blk(2'b10), 10, 7'd10);
    checks++;
    if ({blk_dv_o, blk_data_o, blk_hdr_o} !== {1'b1, last_exp}) begin
      errors++;
      $display("FAIL gap_resume: dv=%b got %h expected %h", blk_dv_o, {blk_data_o, blk_hdr_o}, last_exp);
    end
  endtask

  task automatic test_reset_mid();
    int dv_seen;
    rst_i = 1'b1;
    beat(new_blk(2'b01), 10, 7'd10);
    checks++;
    if ({blk_dv_o, hdr_err_o, blk_lock_o, offset_used_o, blk_hdr_o, blk_data_o} !== 76'd0) begin
      errors++;
      $display("FAIL midreset_zero: dv=%b err=%b lock=%b off=%0d blk=%h expected all 0", blk_dv_o,
               hdr_err_o, blk_lock_o, offset_used_o, {blk_data_o, blk_hdr_o});
    end
    rst_i = 1'b0;
    acquire(10, dv_seen);
    checks++;
    if (dv_seen != 0 || blk_lock_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_relock: dv=%0d lock=%b expected 0 and 0", dv_seen, blk_lock_o);
    end
    beat(new_blk(2'b01), 10, 7'd10);
    checks++;
    if ({blk_dv_o, blk_lock_o, blk_data_o, blk_hdr_o} !== {2'b11, last_exp}) begin
      errors++;
      $display("FAIL midreset_first: dv=%b lock=%b got %h expected %h", blk_dv_o, blk_lock_o,
               {blk_data_o, blk_hdr_o}, last_exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i        = 1'b1;
    buffer_dv    = 1'b0;
    gbox_buffer  = '0;
    gbox_cnt     = '0;
    block_offset = '0;
    test_reset();
    test_lock_offset(10);
    test_lock_offset(0);
    test_lock_offset(65);
    test_bad_headers();
    test_offset_change();
    test_offset_hold();
    test_gaps();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
